// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, data width, line idle level,
// and the clocks-per-bit helper used to size the baud counter.
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // PARITY is only visited when ASCII_UART_TX_PARITY_EN is defined
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Integer clock cycles per serial bit (truncating division)
    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 while enabled and pulses bit_end on
// the last cycle of each bit. clr forces the count back to 0.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic bit_end
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_end = en && (cnt_q == LAST);

    // Next count: clear has priority, wrap to 0 at the end of each bit
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/ascii_uart_tx.sv
// ASCII UART transmitter: accepts one byte per valid/ready handshake and
// sends it LSB first as 8N1. Defining ASCII_UART_TX_PARITY_EN inserts an
// even-parity bit between the data bits and the stop bit.
module ascii_uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 100000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);
    if (CLKS_PER_BIT < 2) begin : g_bad_cfg
        $error("ascii_uart_tx: CLKS_PER_BIT must be at least 2");
    end

    localparam logic [2:0] LAST_IDX = 3'(UART_DATA_BITS - 1);

    uart_state_t state_q, state_d;
    logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic tx_q, tx_d;
    logic bit_end;
`ifdef ASCII_UART_TX_PARITY_EN
    logic parity_q, parity_d;
`endif

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (state_q != IDLE),
        .clr    (state_q == IDLE),
        .bit_end(bit_end)
    );

    // tx comes straight from a flop; ready/busy decode only the state register
    assign tx       = tx_q;
    assign tx_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);

    // Frame sequencing; tx_d is the line level for the cycle after this edge
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
`ifdef ASCII_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = UART_IDLE_LEVEL;
                if (tx_valid) begin
                    shreg_d   = tx_data;
                    bit_idx_d = '0;
                    tx_d      = 1'b0;
                    state_d   = START;
`ifdef ASCII_UART_TX_PARITY_EN
                    parity_d  = ^tx_data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    tx_d    = shreg_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_idx_q == LAST_IDX) begin
`ifdef ASCII_UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = PARITY;
`else
                        tx_d    = UART_IDLE_LEVEL;
                        state_d = STOP;
`endif
                    end else begin
                        tx_d      = shreg_q[1];
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
`ifdef ASCII_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    tx_d    = UART_IDLE_LEVEL;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                tx_d = UART_IDLE_LEVEL;
                if (bit_end) state_d = IDLE;
            end
            default: begin
                tx_d    = UART_IDLE_LEVEL;
                state_d = IDLE;
            end
        endcase
    end

    // State, shift register and line registers; reset idles the line at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= UART_IDLE_LEVEL;
`ifdef ASCII_UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
`ifdef ASCII_UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule
